// File: rtl/ibex_register_file_mp.sv
// Multi-port flip-flop register file with optional write bypass, a clear engine
// that walks the array back to its reset value, and a registered error pulse.
module ibex_register_file_mp #(
    parameter bit                   RV32E         = 1'b0,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          NumReadPorts  = 2,
    parameter int unsigned          NumWritePorts = 1,
    parameter bit                   WriteBypass   = 1'b0,
    parameter logic [DataWidth-1:0] WordZeroVal   = '0
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic [5*NumReadPorts-1:0]          raddr_i,
    output logic [DataWidth*NumReadPorts-1:0]  rdata_o,
    input  logic [5*NumWritePorts-1:0]         waddr_i,
    input  logic [DataWidth*NumWritePorts-1:0] wdata_i,
    input  logic [NumWritePorts-1:0]           we_i,
    input  logic                               clear_req_i,
    output logic                               clear_busy_o,
    output logic                               clear_done_o,
    output logic                               err_o
);

    localparam int unsigned NumWords = RV32E ? 16 : 32;
    localparam int unsigned AddrW    = RV32E ? 4 : 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [AddrW-1:0]       cnt_q, cnt_d;
    logic                   clear_wr;
    logic [DataWidth-1:0]   mem_q [NumWords];
    logic [AddrW-1:0]       wa [NumWritePorts];
    logic [NumWritePorts-1:0] wr_eff, wr_ill;
    logic                   collide, err_d;

    always_comb begin
        logic legal;
        legal = 1'b1;
        for (int w = 0; w < NumWritePorts; w++) begin
            wa[w]     = waddr_i[5*w +: AddrW];
            legal     = RV32E ? ~waddr_i[5*w+4] : 1'b1;
            wr_eff[w] = we_i[w] && (state_q == IDLE) && legal && (wa[w] != '0);
            wr_ill[w] = we_i[w] && !((state_q == IDLE) && legal);
        end
    end

    // Port collision is only meaningful with two write ports
    assign collide = (NumWritePorts == 2) && wr_eff[0] && wr_eff[NumWritePorts-1] &&
                     (wa[0] == wa[NumWritePorts-1]);
    assign err_d   = (|wr_ill) | collide;

    always_comb begin
        logic [4:0]           ra;
        logic                 rv;
        logic [DataWidth-1:0] rd;
        rdata_o = '0;
        for (int p = 0; p < NumReadPorts; p++) begin
            ra = raddr_i[5*p +: 5];
            rv = RV32E ? ~ra[4] : 1'b1;
            rd = WordZeroVal;
            if (rv && (ra != 5'd0)) begin
                rd = mem_q[ra[AddrW-1:0]];
                if (WriteBypass) begin
                    for (int w = 0; w < NumWritePorts; w++) begin
                        if (wr_eff[w] && (wa[w] == ra[AddrW-1:0])) begin
                            rd = wdata_i[DataWidth*w +: DataWidth];
                        end
                    end
                end
            end
            rdata_o[DataWidth*p +: DataWidth] = rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= AddrW'(1);
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear_req_i) begin
                    state_d = CLEAR;
                    cnt_d   = AddrW'(1);
                end
            end
            CLEAR: begin
                if (cnt_q == AddrW'(NumWords - 1)) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = AddrW'(1);
            end
            default: begin
                state_d = IDLE;
                cnt_d   = AddrW'(1);
            end
        endcase
    end

    always_comb begin
        clear_busy_o = (state_q != IDLE);
        clear_done_o = (state_q == DONE);
        clear_wr     = (state_q == CLEAR);
    end

    // Word 0 is reset with the rest but never written, so it stays at WordZeroVal
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < NumWords; k++) begin
                mem_q[k] <= WordZeroVal;
            end
        end else begin
            for (int w = 0; w < NumWritePorts; w++) begin
                if (wr_eff[w]) begin
                    mem_q[wa[w]] <= wdata_i[DataWidth*w +: DataWidth];
                end
            end
            if (clear_wr) begin
                mem_q[cnt_q] <= WordZeroVal;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else begin
            err_o <= err_d;
        end
    end

endmodule

// File: tb/tb_ibex_register_file_mp.sv
// Bench for two register file configurations: dual-write with bypass (A) and
// RV32E single-write without bypass and a nonzero reset value (B).
module tb_ibex_register_file_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra [2][2];
    logic [4:0]  wa [2][2];
    logic [31:0] wd [2][2];
    logic        we [2][2];
    logic        creq [2];

    logic [63:0] a_rdata, b_rdata;
    logic        a_busy, a_done, a_err, b_busy, b_done, b_err;

    always #5 clk = ~clk;

    ibex_register_file_mp #(
        .RV32E(1'b0), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(2),
        .WriteBypass(1'b1), .WordZeroVal(32'h0)
    ) dut_a (
        .clk_i(clk), .rst_i(rst),
        .raddr_i({ra[0][1], ra[0][0]}), .rdata_o(a_rdata),
        .waddr_i({wa[0][1], wa[0][0]}), .wdata_i({wd[0][1], wd[0][0]}),
        .we_i({we[0][1], we[0][0]}), .clear_req_i(creq[0]),
        .clear_busy_o(a_busy), .clear_done_o(a_done), .err_o(a_err)
    );

    ibex_register_file_mp #(
        .RV32E(1'b1), .DataWidth(32), .NumReadPorts(2), .NumWritePorts(1),
        .WriteBypass(1'b0), .WordZeroVal(32'hCAFE0000)
    ) dut_b (
        .clk_i(clk), .rst_i(rst),
        .raddr_i({ra[1][1], ra[1][0]}), .rdata_o(b_rdata),
        .waddr_i(wa[1][0]), .wdata_i(wd[1][0]),
        .we_i(we[1][0]), .clear_req_i(creq[1]),
        .clear_busy_o(b_busy), .clear_done_o(b_done), .err_o(b_err)
    );

    // Reference model: word array plus the number of cycles since a clear was accepted
    int          nw  [2] = '{32, 16};
    int          nwp [2] = '{2, 1};
    bit          byp [2] = '{1'b1, 1'b0};
    logic [31:0] zv  [2] = '{32'h0, 32'hCAFE0000};
    logic [31:0] mm  [2][32];
    int          age [2];
    logic        merr [2];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_rd(input int d, input int p);
        return (d == 0) ? a_rdata[32*p +: 32] : b_rdata[32*p +: 32];
    endfunction
    function automatic logic busy_act(input int d);
        return (d == 0) ? a_busy : b_busy;
    endfunction
    function automatic logic done_act(input int d);
        return (d == 0) ? a_done : b_done;
    endfunction
    function automatic logic err_act(input int d);
        return (d == 0) ? a_err : b_err;
    endfunction

    function automatic bit eff(input int d, input int w);
        return (w < nwp[d]) && we[d][w] && (age[d] == 0) &&
               (int'(wa[d][w]) < nw[d]) && (wa[d][w] != 5'd0);
    endfunction

    function automatic logic [31:0] exp_rd(input int d, input int p);
        int a;
        logic [31:0] r;
        a = int'(ra[d][p]);
        if (a >= nw[d] || a == 0) return zv[d];
        r = mm[d][a];
        if (byp[d]) begin
            for (int w = 0; w < 2; w++) begin
                if (eff(d, w) && int'(wa[d][w]) == a) r = wd[d][w];
            end
        end
        return r;
    endfunction

    task automatic model_edge();
        bit e;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                for (int k = 0; k < 32; k++) mm[d][k] = zv[d];
                age[d]  = 0;
                merr[d] = 1'b0;
            end else begin
                e = 1'b0;
                for (int w = 0; w < nwp[d]; w++) begin
                    if (we[d][w] && (age[d] != 0 || int'(wa[d][w]) >= nw[d])) e = 1'b1;
                end
                if (nwp[d] == 2 && eff(d, 0) && eff(d, 1) && wa[d][0] == wa[d][1]) e = 1'b1;
                for (int w = 0; w < 2; w++) begin
                    if (eff(d, w)) mm[d][wa[d][w]] = wd[d][w];
                end
                if (age[d] >= 1 && age[d] <= nw[d] - 1) mm[d][age[d]] = zv[d];
                if (age[d] == 0) age[d] = creq[d] ? 1 : 0;
                else if (age[d] == nw[d]) age[d] = 0;
                else age[d] = age[d] + 1;
                merr[d] = e;
            end
        end
    endtask

    task automatic check_all();
        for (int d = 0; d < 2; d++) begin
            for (int p = 0; p < 2; p++) begin
                chk($sformatf("rdata d%0d p%0d ra=%0d", d, p, ra[d][p]), act_rd(d, p), exp_rd(d, p));
            end
            chk($sformatf("busy d%0d", d), {31'b0, busy_act(d)}, {31'b0, age[d] != 0});
            chk($sformatf("done d%0d", d), {31'b0, done_act(d)}, {31'b0, age[d] == nw[d]});
            chk($sformatf("err d%0d", d), {31'b0, err_act(d)}, {31'b0, merr[d]});
        end
    endtask

    // Called at the falling edge with inputs already applied
    task automatic step();
        #1;
        check_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            creq[d] = 1'b0;
            for (int w = 0; w < 2; w++) begin
                we[d][w] = 1'b0; wa[d][w] = 5'd0; wd[d][w] = 32'h0; ra[d][w] = 5'd0;
            end
        end
    endtask

    task automatic read_all(input int d, input bit expect_zero);
        for (int a = 0; a < 32; a++) begin
            ra[d][0] = 5'(a);
            ra[d][1] = 5'(31 - a);
            if (expect_zero) begin
                #1;
                chk($sformatf("zero d%0d x%0d", d, a), act_rd(d, 0), zv[d]);
            end
            step();
        end
    endtask

    task automatic fill(input int d);
        for (int k = 1; k < nw[d]; k++) begin
            we[d][0] = 1'b1;
            wa[d][0] = 5'(k);
            wd[d][0] = $urandom | 32'h1;
            step();
        end
        we[d][0] = 1'b0;
    endtask

    task automatic run_clear(input int d, input int len, input bit inject);
        int cnt, done_at;
        cnt = 0;
        done_at = 0;
        creq[d] = 1'b1;
        step();
        creq[d] = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_act(d)) break;
            cnt++;
            if (done_act(d)) done_at = cnt;
            if (inject && cnt == 5) begin
                we[d][0] = 1'b1; wa[d][0] = 5'd5; wd[d][0] = 32'h77;
            end
            if (inject && cnt == 6) begin
                we[d][0] = 1'b0;
                #1;
                chk("err after write during clear", {31'b0, err_act(d)}, 32'd1);
            end
            step();
        end
        chk($sformatf("clear length d%0d", d), cnt, len);
        chk($sformatf("done cycle d%0d", d), done_at, len);
    endtask

    typedef struct {
        logic        we0; logic [4:0] wa0; logic [31:0] wd0;
        logic        we1; logic [4:0] wa1; logic [31:0] wd1;
        logic [4:0]  ra0; logic [4:0] ra1;
        logic [31:0] e0;  logic [31:0] e1; logic eerr;
    } vec_t;

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        tbl[2] = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 32'h0,  5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[3] = '{1'b1, 5'd7, 32'h11,       1'b1, 5'd7, 32'h22, 5'd7, 5'd0, 32'h22,       32'h0,        1'b0};
        tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd7, 5'd7, 32'h22,       32'h22,       1'b1};
        tbl[5] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd3, 5'd7, 32'h0,        32'h22,       1'b0};
        tbl[6] = '{1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 32'h0,  5'd3, 5'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0};
        tbl[7] = '{1'b1, 5'd4, 32'h1,        1'b1, 5'd9, 32'h2,  5'd4, 5'd9, 32'h1,        32'h2,        1'b0};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,  5'd4, 5'd9, 32'h1,        32'h2,        1'b0};

        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;

        #1;
        chk("reset busy A", {31'b0, a_busy}, 32'd0);
        chk("reset err A", {31'b0, a_err}, 32'd0);
        read_all(0, 1'b1);
        read_all(1, 1'b1);

        for (int i = 0; i < 9; i++) begin
            we[0][0] = tbl[i].we0; wa[0][0] = tbl[i].wa0; wd[0][0] = tbl[i].wd0;
            we[0][1] = tbl[i].we1; wa[0][1] = tbl[i].wa1; wd[0][1] = tbl[i].wd1;
            ra[0][0] = tbl[i].ra0; ra[0][1] = tbl[i].ra1;
            #1;
            chk($sformatf("vec%0d r0", i), a_rdata[31:0], tbl[i].e0);
            chk($sformatf("vec%0d r1", i), a_rdata[63:32], tbl[i].e1);
            chk($sformatf("vec%0d err", i), {31'b0, a_err}, {31'b0, tbl[i].eerr});
            step();
        end
        idle_inputs();

        // No bypass: same-cycle read sees the old value
        we[1][0] = 1'b1; wa[1][0] = 5'd3; wd[1][0] = 32'h11111111;
        step();
        wd[1][0] = 32'hA5A5A5A5; ra[1][0] = 5'd3; ra[1][1] = 5'd3;
        #1;
        chk("nobypass old p0", b_rdata[31:0], 32'h11111111);
        chk("nobypass old p1", b_rdata[63:32], 32'h11111111);
        step();
        we[1][0] = 1'b0;
        #1;
        chk("nobypass new", b_rdata[31:0], 32'hA5A5A5A5);
        step();

        // RV32E: upper-half address is illegal
        we[1][0] = 1'b1; wa[1][0] = 5'd20; wd[1][0] = 32'hFF; ra[1][0] = 5'd20;
        #1;
        chk("rv32e read x20", b_rdata[31:0], 32'hCAFE0000);
        step();
        we[1][0] = 1'b0;
        #1;
        chk("rv32e err", {31'b0, b_err}, 32'd1);
        step();
        #1;
        chk("rv32e err clears", {31'b0, b_err}, 32'd0);
        chk("rv32e x20 after", b_rdata[31:0], 32'hCAFE0000);
        step();

        fill(1);
        run_clear(1, 16, 1'b0);
        read_all(1, 1'b1);

        fill(0);
        run_clear(0, 32, 1'b1);
        read_all(0, 1'b1);

        // Reset in the middle of a clear
        fill(0);
        creq[0] = 1'b1;
        step();
        creq[0] = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("busy after mid-clear reset", {31'b0, a_busy}, 32'd0);
        read_all(0, 1'b1);

        for (int c = 0; c < 400; c++) begin
            for (int d = 0; d < 2; d++) begin
                creq[d] = ($urandom_range(0, 39) == 0);
                for (int w = 0; w < 2; w++) begin
                    we[d][w] = (w < nwp[d]) && ($urandom_range(0, 2) == 0);
                    wa[d][w] = 5'($urandom_range(0, 31));
                    wd[d][w] = $urandom;
                    ra[d][w] = ($urandom_range(0, 3) == 0) ? wa[d][0] : 5'($urandom_range(0, 31));
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
